branch_sequencer: RTL and testbench

- Control sequencer for all PC-altering and two-word instructions of the 4-bit CPU core.
- Sits between `rom`/`clockReset` and the `pc`, `stack`, `registerFile` and `accTempRegs` blocks.
- Latches OPR/OPA each machine cycle and tracks one-word vs. two-word instruction state.
- Issues single-cycle load/push/pop/write strobes in X3 to execute JUN, JMS, JCN, ISZ, FIM, JIN and BBL.

---
 rtl/branch_sequencer.sv | 176 +++++++++++++++++
 tb/tb_branch_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_sequencer.sv
// Execute sequencer for PC-altering and two-word instructions: latches OPR/OPA,
// tracks first/second word, and issues single-cycle X3 strobes.
module branch_sequencer #(
  parameter int M1_CYC = 3,
  parameter int M2_CYC = 4,
  parameter int X3_CYC = 7
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic [2:0]  cycle,
  input  logic [3:0]  romData,
  input  logic [11:0] pcAddr,
  input  logic        accZero,
  input  logic        carryFlag,
  input  logic        testIn,
  input  logic [3:0]  regDout,
  input  logic [7:0]  pairDout,
  input  logic [11:0] stackPcOut,
  output logic        pcLoad,
  output logic [11:0] pcNew,
  output logic        push,
  output logic [11:0] stackPcIn,
  output logic        pop,
  output logic        regWe,
  output logic [3:0]  regAddr,
  output logic [3:0]  regDin,
  output logic        pairWe,
  output logic [3:0]  pairAddr,
  output logic [7:0]  pairDin,
  output logic        accLoad,
  output logic [3:0]  accData,
  output logic        secondWord
);

  typedef enum logic {FIRST = 1'b0, SECOND = 1'b1} state_t;

  localparam logic [3:0] OP_JCN = 4'h1;
  localparam logic [3:0] OP_FIM = 4'h2;
  localparam logic [3:0] OP_JIN = 4'h3;
  localparam logic [3:0] OP_JUN = 4'h4;
  localparam logic [3:0] OP_JMS = 4'h5;
  localparam logic [3:0] OP_ISZ = 4'h7;
  localparam logic [3:0] OP_BBL = 4'hC;

  state_t      state_q, state_d;
  logic [3:0]  opr_q, opr_d;
  logic [3:0]  opa_q, opa_d;
  logic [3:0]  opr1_q, opr1_d;
  logic [3:0]  opa1_q, opa1_d;

  logic        is_m1, is_m2, is_x3;
  logic        two_word;
  logic [7:0]  word2;
  logic [11:0] pc_plus1;
  logic [3:0]  page_next;
  logic [3:0]  isz_inc;
  logic [3:0]  idx_sel;
  logic        jcn_cond;
  logic        jcn_taken;

  assign is_m1     = (cycle == 3'(M1_CYC));
  assign is_m2     = (cycle == 3'(M2_CYC));
  assign is_x3     = (cycle == 3'(X3_CYC));
  assign two_word  = (opr_q == OP_JCN) || (opr_q == OP_JUN) || (opr_q == OP_JMS) ||
                     (opr_q == OP_ISZ) || ((opr_q == OP_FIM) && !opa_q[0]);
  assign word2     = {opr_q, opa_q};
  assign pc_plus1  = pcAddr + 12'd1;
  assign page_next = pc_plus1[11:8];
  assign isz_inc   = regDout + 4'd1;
  assign idx_sel   = (state_q == SECOND) ? opa1_q : opa_q;
  assign jcn_cond  = (opa1_q[2] & accZero) | (opa1_q[1] & carryFlag) | (opa1_q[0] & ~testIn);
  assign jcn_taken = opa1_q[3] ? ~jcn_cond : jcn_cond;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q <= FIRST;
      opr_q   <= 4'h0;
      opa_q   <= 4'h0;
      opr1_q  <= 4'h0;
      opa1_q  <= 4'h0;
    end else begin
      state_q <= state_d;
      opr_q   <= opr_d;
      opa_q   <= opa_d;
      opr1_q  <= opr1_d;
      opa1_q  <= opa1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    opr_d   = opr_q;
    opa_d   = opa_q;
    opr1_d  = opr1_q;
    opa1_d  = opa1_q;
    if (is_m1) opr_d = romData;
    if (is_m2) opa_d = romData;
    if (is_x3) begin
      case (state_q)
        FIRST: begin
          if (two_word) begin
            opr1_d  = opr_q;
            opa1_d  = opa_q;
            state_d = SECOND;
          end
        end
        default: state_d = FIRST;
      endcase
    end
  end

  always_comb begin
    pcLoad     = 1'b0;
    pcNew      = 12'h000;
    push       = 1'b0;
    stackPcIn  = 12'h000;
    pop        = 1'b0;
    regWe      = 1'b0;
    regAddr    = idx_sel;
    regDin     = 4'h0;
    pairWe     = 1'b0;
    pairAddr   = {idx_sel[3:1], 1'b0};
    pairDin    = 8'h00;
    accLoad    = 1'b0;
    accData    = 4'h0;
    secondWord = (state_q == SECOND);
    // Strobes are held off while reset is asserted, even in X3.
    if (is_x3 && rstN) begin
      if (state_q == FIRST) begin
        if ((opr_q == OP_JIN) && opa_q[0]) begin
          pcLoad = 1'b1;
          pcNew  = {pcAddr[11:8], pairDout};
        end else if (opr_q == OP_BBL) begin
          pop     = 1'b1;
          pcLoad  = 1'b1;
          pcNew   = stackPcOut;
          accLoad = 1'b1;
          accData = opa_q;
        end
      end else begin
        case (opr1_q)
          OP_JUN: begin
            pcLoad = 1'b1;
            pcNew  = {opa1_q, word2};
          end
          OP_JMS: begin
            push      = 1'b1;
            stackPcIn = pc_plus1;
            pcLoad    = 1'b1;
            pcNew     = {opa1_q, word2};
          end
          OP_JCN: begin
            if (jcn_taken) begin
              pcLoad = 1'b1;
              pcNew  = {page_next, word2};
            end
          end
          OP_ISZ: begin
            regWe  = 1'b1;
            regDin = isz_inc;
            if (isz_inc != 4'h0) begin
              pcLoad = 1'b1;
              pcNew  = {page_next, word2};
            end
          end
          OP_FIM: begin
            pairWe  = 1'b1;
            pairDin = word2;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Word-level bench: drives 8-cycle machine cycles per ROM word and compares
// the X3 strobes against an instruction-level reference model.
module tb_branch_sequencer;

  logic        clk = 1'b0;
  logic        rstN;
  logic [2:0]  cycle;
  logic [3:0]  romData;
  logic [11:0] pcAddr;
  logic        accZero, carryFlag, testIn;
  logic [3:0]  regDout;
  logic [7:0]  pairDout;
  logic [11:0] stackPcOut;
  logic        pcLoad, push, pop, regWe, pairWe, accLoad, secondWord;
  logic [11:0] pcNew, stackPcIn;
  logic [3:0]  regAddr, regDin, pairAddr, accData;
  logic [7:0]  pairDin;

  int n_total = 0;
  int n_bad   = 0;

  // model: pending second word and the first word it belongs to
  bit         m_pend = 1'b0;
  logic [3:0] m_opr1 = 4'h0;
  logic [3:0] m_opa1 = 4'h0;

  // values seen in the last X3, for the directed literal checks
  logic        l_pcLoad, l_push, l_pop, l_regWe, l_pairWe, l_accLoad;
  logic [11:0] l_pcNew, l_stackPcIn;
  logic [3:0]  l_regDin, l_pairAddr, l_accData;
  logic [7:0]  l_pairDin;
  int          l_seccnt;

  branch_sequencer dut (
    .clk(clk), .rstN(rstN), .cycle(cycle), .romData(romData), .pcAddr(pcAddr),
    .accZero(accZero), .carryFlag(carryFlag), .testIn(testIn), .regDout(regDout),
    .pairDout(pairDout), .stackPcOut(stackPcOut), .pcLoad(pcLoad), .pcNew(pcNew),
    .push(push), .stackPcIn(stackPcIn), .pop(pop), .regWe(regWe), .regAddr(regAddr),
    .regDin(regDin), .pairWe(pairWe), .pairAddr(pairAddr), .pairDin(pairDin),
    .accLoad(accLoad), .accData(accData), .secondWord(secondWord)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_word(input logic [7:0] w, input logic [11:0] addr);
    logic [3:0]  hi, lo, e_ra, inc, pn;
    logic [11:0] a1, e_pcNew, e_spi;
    logic        e_pcLoad, e_push, e_pop, e_regWe, e_pairWe, e_accLoad, e_sec, cond;
    logic [3:0]  e_regDin, e_accData;
    logic [7:0]  e_pairDin;
    hi = w[7:4]; lo = w[3:0];
    a1 = addr + 12'd1; pn = a1[11:8];
    e_pcLoad = 0; e_push = 0; e_pop = 0; e_regWe = 0; e_pairWe = 0; e_accLoad = 0;
    e_pcNew = 0; e_spi = 0; e_regDin = 0; e_accData = 0; e_pairDin = 0;
    e_sec = m_pend;
    e_ra  = m_pend ? m_opa1 : lo;
    if (!m_pend) begin
      if (hi == 4'h3 && lo[0]) begin
        e_pcLoad = 1; e_pcNew = {addr[11:8], pairDout};
      end else if (hi == 4'hC) begin
        e_pop = 1; e_pcLoad = 1; e_pcNew = stackPcOut; e_accLoad = 1; e_accData = lo;
      end
    end else begin
      case (m_opr1)
        4'h4: begin e_pcLoad = 1; e_pcNew = {m_opa1, w}; end
        4'h5: begin e_push = 1; e_spi = a1; e_pcLoad = 1; e_pcNew = {m_opa1, w}; end
        4'h1: begin
          cond = (m_opa1[2] && accZero) || (m_opa1[1] && carryFlag) || (m_opa1[0] && !testIn);
          if (cond != m_opa1[3]) begin e_pcLoad = 1; e_pcNew = {pn, w}; end
        end
        4'h7: begin
          inc = regDout + 4'd1;
          e_regWe = 1; e_regDin = inc;
          if (inc != 0) begin e_pcLoad = 1; e_pcNew = {pn, w}; end
        end
        4'h2: begin e_pairWe = 1; e_pairDin = w; end
        default: ;
      endcase
    end
    l_seccnt = 0;
    for (int c = 0; c < 8; c++) begin
      pcAddr  = addr;
      cycle   = 3'(c);
      romData = (c == 3) ? hi : (c == 4) ? lo : 4'($urandom);
      @(negedge clk);
      if (secondWord) l_seccnt++;
      chk("secondWord", secondWord, e_sec);
      if (m_pend) chk("regAddr_sec", regAddr, m_opa1);
      if (c != 7) begin
        chk("idle_strobes", {pcLoad, push, pop, regWe, pairWe, accLoad}, 0);
        chk("idle_data", {pcNew, stackPcIn, regDin, pairDin, accData}, 0);
      end else begin
        chk("pcLoad", pcLoad, e_pcLoad);
        chk("pcNew", pcNew, e_pcNew);
        chk("push", push, e_push);
        chk("stackPcIn", stackPcIn, e_spi);
        chk("pop", pop, e_pop);
        chk("regWe", regWe, e_regWe);
        chk("regAddr", regAddr, e_ra);
        chk("regDin", regDin, e_regDin);
        chk("pairWe", pairWe, e_pairWe);
        chk("pairAddr", pairAddr, {e_ra[3:1], 1'b0});
        chk("pairDin", pairDin, e_pairDin);
        chk("accLoad", accLoad, e_accLoad);
        chk("accData", accData, e_accData);
        l_pcLoad = pcLoad; l_pcNew = pcNew; l_push = push; l_stackPcIn = stackPcIn;
        l_pop = pop; l_regWe = regWe; l_regDin = regDin; l_pairWe = pairWe;
        l_pairAddr = pairAddr; l_pairDin = pairDin; l_accLoad = accLoad; l_accData = accData;
      end
      @(posedge clk); #1;
    end
    $display("word addr=%03h data=%02h second=%0d pcLoad=%0d pcNew=%03h", addr, w, e_sec, l_pcLoad, l_pcNew);
    if (!m_pend && (hi == 4'h1 || hi == 4'h4 || hi == 4'h5 || hi == 4'h7 || (hi == 4'h2 && !lo[0]))) begin
      m_pend = 1; m_opr1 = hi; m_opa1 = lo;
    end else begin
      m_pend = 0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ops [8];
    logic [3:0] opr;
    logic [11:0] addr;
    ops = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'hC, 4'h0};
    rstN = 0; cycle = 3'd7; romData = 0; pcAddr = 0; accZero = 0; carryFlag = 0;
    testIn = 1; regDout = 0; pairDout = 0; stackPcOut = 12'h123;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_strobes", {pcLoad, push, pop, regWe, pairWe, accLoad}, 0);
    chk("rst_second", secondWord, 0);
    chk("rst_regAddr", regAddr, 0);
    @(posedge clk); #1;
    rstN = 1;

    // JUN
    do_word(8'h4A, 12'h010);
    chk("jun_w1_pcLoad", l_pcLoad, 0);
    chk("jun_w1_sec", l_seccnt, 0);
    do_word(8'h35, 12'h011);
    chk("jun_pcLoad", l_pcLoad, 1);
    chk("jun_pcNew", l_pcNew, 12'hA35);
    chk("jun_sec8", l_seccnt, 8);
    // JMS then BBL
    do_word(8'h51, 12'h020);
    do_word(8'h00, 12'h021);
    chk("jms_push", l_push, 1);
    chk("jms_spi", l_stackPcIn, 12'h022);
    chk("jms_pcNew", l_pcNew, 12'h100);
    stackPcOut = 12'h022;
    do_word(8'hC7, 12'h100);
    chk("bbl_pop", l_pop, 1);
    chk("bbl_pcNew", l_pcNew, 12'h022);
    chk("bbl_acc", {l_accLoad, l_accData}, 5'h17);
    // JCN
    accZero = 1; carryFlag = 0; testIn = 1;
    do_word(8'h14, 12'h040); do_word(8'h80, 12'h041);
    chk("jcn_az_pcNew", {l_pcLoad, l_pcNew}, 13'h1080);
    accZero = 0;
    do_word(8'h14, 12'h040); do_word(8'h80, 12'h041);
    chk("jcn_nz_pcLoad", l_pcLoad, 0);
    do_word(8'h1C, 12'h040); do_word(8'h80, 12'h041);
    chk("jcn_inv_pcLoad", l_pcLoad, 1);
    // ISZ
    regDout = 4'hE;
    do_word(8'h73, 12'h060); do_word(8'h50, 12'h061);
    chk("isz_we", {l_regWe, l_regDin}, 5'h1F);
    chk("isz_jump", {l_pcLoad, l_pcNew}, 13'h1050);
    regDout = 4'hF;
    do_word(8'h73, 12'h060); do_word(8'h50, 12'h061);
    chk("isz_wrap_din", {l_regWe, l_regDin}, 5'h10);
    chk("isz_wrap_nojump", l_pcLoad, 0);
    regDout = 4'hE;
    do_word(8'h73, 12'h0FE); do_word(8'h50, 12'h0FF);
    chk("isz_page", l_pcNew, 12'h150);
    do_word(8'h73, 12'hFFE); do_word(8'h50, 12'hFFF);
    chk("isz_pageF", l_pcNew, 12'h050);
    // FIM then JIN
    do_word(8'h24, 12'h070); do_word(8'hAB, 12'h071);
    chk("fim", {l_pairWe, l_pairAddr, l_pairDin}, 13'h14AB);
    pairDout = 8'h12;
    do_word(8'h35, 12'h300);
    chk("jin", {l_pcLoad, l_pcNew}, 13'h1312);

    // reset abandoning a JUN in its second word
    do_word(8'h4A, 12'h500);
    for (int c = 0; c < 7; c++) begin
      cycle = 3'(c);
      romData = 4'($urandom);
      rstN = (c == 6) ? 1'b0 : 1'b1;
      @(negedge clk);
      chk("midrst_sec", secondWord, 1);
      @(posedge clk); #1;
    end
    rstN = 1; cycle = 3'd7;
    @(negedge clk);
    chk("midrst_state", secondWord, 0);
    chk("midrst_strobes", {pcLoad, push, pop, regWe, pairWe, accLoad}, 0);
    @(posedge clk); #1;
    $display("word reset during second word of JUN");
    m_pend = 0;
    stackPcOut = 12'h123;
    do_word(8'hC3, 12'h601);
    chk("midrst_next_pop", {l_pop, l_pcNew}, 13'h1123);

    // randomized words
    for (int i = 0; i < 300; i++) begin
      opr = ops[$urandom_range(0, 7)];
      if (opr == 4'h0) opr = 4'($urandom);
      addr = 12'($urandom);
      if ($urandom_range(0, 3) == 0) addr[7:0] = 8'hFF;
      accZero = 1'($urandom); carryFlag = 1'($urandom); testIn = 1'($urandom);
      regDout = 4'($urandom); pairDout = 8'($urandom); stackPcOut = 12'($urandom);
      do_word({opr, 4'($urandom)}, addr);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
